// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared PWM definitions: data width, default period and the sequencer state encoding.
// Both the generator and the sequencer pull PERIOD_CLKS from here so their periods agree.
package pwm_duty_sequencer_pkg;

  localparam int DATA_W              = 8;
  localparam int DEFAULT_PERIOD_CLKS = 4096;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Control/status bundle between a duty-cycle requester (master) and the sequencer (slave).
interface pwm_duty_sequencer_if
  import pwm_duty_sequencer_pkg::*;
();

  logic              load;
  logic [DATA_W-1:0] target;
  logic              kill;
  logic [DATA_W-1:0] CompDat;
  logic              busy;
  logic              done;
  logic              period_tick;

  modport master (
    output load, target, kill,
    input  CompDat, busy, done, period_tick
  );

  modport slave (
    input  load, target, kill,
    output CompDat, busy, done, period_tick
  );

endinterface

// File: rtl/pwm_duty_sequencer_period_timer.sv
// Free-running PWM period counter; o_period_tick marks the last clock of each period.
// Shared with the generator so both count in lockstep.
module pwm_period_timer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int PERIOD_CLKS = DEFAULT_PERIOD_CLKS
) (
  input  logic clk,
  input  logic rst,
  output logic o_period_tick
);

  localparam int             CW   = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(PERIOD_CLKS - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_period_tick = (r_count == LAST);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Slews the PWM compare value toward a requested duty in bounded steps, updating only
// on period boundaries; kill forces the compare value to zero at the next edge.
module pwm_duty_sequencer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int PERIOD_CLKS      = DEFAULT_PERIOD_CLKS,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_duty_sequencer_if.slave   sif
);

  localparam int                SW        = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [SW-1:0]     STEP_LAST = SW'(PERIODS_PER_STEP - 1);
  localparam logic [DATA_W:0]   STEP_EXT  = (DATA_W + 1)'(STEP);

  logic              w_tick;
  seq_state_t        r_state, w_state_next;
  logic [DATA_W-1:0] r_comp, w_comp_next;
  logic [DATA_W-1:0] r_tgt, w_tgt_next;
  logic [SW-1:0]     r_step, w_step_next;
  logic              r_done, w_done_next;

  logic [DATA_W:0]   w_sum, w_diff;
  logic [DATA_W-1:0] w_up_val, w_dn_val, w_new_val;

  pwm_period_timer #(.PERIOD_CLKS(PERIOD_CLKS)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .o_period_tick (w_tick)
  );

  // 9-bit arithmetic so a step past 255 or below 0 is seen as overshoot, then clamped to target.
  assign w_sum     = {1'b0, r_comp} + STEP_EXT;
  assign w_diff    = {1'b0, r_comp} - STEP_EXT;
  assign w_up_val  = (w_sum >= {1'b0, r_tgt}) ? r_tgt : w_sum[DATA_W-1:0];
  assign w_dn_val  = (w_diff[DATA_W] || (w_diff[DATA_W-1:0] <= r_tgt)) ? r_tgt : w_diff[DATA_W-1:0];
  assign w_new_val = (r_state == ST_RAMP_UP) ? w_up_val : w_dn_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_comp  <= '0;
      r_tgt   <= '0;
      r_step  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_comp  <= w_comp_next;
      r_tgt   <= w_tgt_next;
      r_step  <= w_step_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_comp_next  = r_comp;
    w_tgt_next   = r_tgt;
    w_step_next  = r_step;
    w_done_next  = 1'b0;
    if (sif.kill) begin
      w_state_next = ST_IDLE;
      w_comp_next  = '0;
      w_step_next  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_step_next = '0;
          if (sif.load) begin
            w_tgt_next = sif.target;
            if (sif.target > r_comp) begin
              w_state_next = ST_RAMP_UP;
            end else if (sif.target < r_comp) begin
              w_state_next = ST_RAMP_DOWN;
            end else begin
              w_done_next = 1'b1;
            end
          end
        end
        ST_RAMP_UP, ST_RAMP_DOWN: begin
          if (w_tick) begin
            if (r_step == STEP_LAST) begin
              w_step_next = '0;
              w_comp_next = w_new_val;
              if (w_new_val == r_tgt) begin
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
              end
            end else begin
              w_step_next = r_step + SW'(1);
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign sif.CompDat     = r_comp;
  assign sif.busy        = (r_state != ST_IDLE);
  assign sif.done        = r_done;
  assign sif.period_tick = w_tick;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench: three sequencer instances (different STEP / PERIODS_PER_STEP) on an
// 8-clock PWM period, driven from a table of ramps plus hand-written corner sequences.
module tb_pwm_duty_sequencer;
  import pwm_duty_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic       load_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] tgt_v  [3] = '{8'd0, 8'd0, 8'd0};
  logic       kill_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] comp   [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       tick_w [3];

  pwm_duty_sequencer_if if0 ();
  pwm_duty_sequencer_if if1 ();
  pwm_duty_sequencer_if if2 ();

  assign if0.load = load_v[0]; assign if0.target = tgt_v[0]; assign if0.kill = kill_v[0];
  assign if1.load = load_v[1]; assign if1.target = tgt_v[1]; assign if1.kill = kill_v[1];
  assign if2.load = load_v[2]; assign if2.target = tgt_v[2]; assign if2.kill = kill_v[2];
  assign comp[0] = if0.CompDat; assign busy_w[0] = if0.busy; assign done_w[0] = if0.done; assign tick_w[0] = if0.period_tick;
  assign comp[1] = if1.CompDat; assign busy_w[1] = if1.busy; assign done_w[1] = if1.done; assign tick_w[1] = if1.period_tick;
  assign comp[2] = if2.CompDat; assign busy_w[2] = if2.busy; assign done_w[2] = if2.done; assign tick_w[2] = if2.period_tick;

  pwm_duty_sequencer #(.PERIOD_CLKS(8), .STEP(1),  .PERIODS_PER_STEP(1)) u_dut0 (.clk(clk), .rst(rst), .sif(if0.slave));
  pwm_duty_sequencer #(.PERIOD_CLKS(8), .STEP(3),  .PERIODS_PER_STEP(2)) u_dut1 (.clk(clk), .rst(rst), .sif(if1.slave));
  pwm_duty_sequencer #(.PERIOD_CLKS(8), .STEP(16), .PERIODS_PER_STEP(1)) u_dut2 (.clk(clk), .rst(rst), .sif(if2.slave));

  int total = 0;
  int bad   = 0;
  int pps_of [3] = '{1, 2, 1};

  typedef struct packed {
    logic [1:0]       dut;
    logic [7:0]       tgt;
    logic [4:0]       n;
    logic             disturb;
    logic [16:0][7:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_load(input int d, input logic [7:0] t);
    @(posedge clk); #1;
    tgt_v[d]  = t;
    load_v[d] = 1'b1;
    @(posedge clk); #1;
    load_v[d] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int         d;
    int         ticks;
    int         idx;
    int         cycles;
    logic       t;
    logic       pend;
    logic [7:0] prev;
    d = int'(v.dut); ticks = 0; idx = 0; cycles = 0; pend = 1'b0;
    do_load(d, v.tgt);
    chk("ramp_busy_start", busy_w[d], 1);
    prev = comp[d];
    while (idx < int'(v.n) && cycles < 2000) begin
      t = tick_w[d];
      @(posedge clk); #1;
      cycles++;
      if (pend) begin load_v[d] = 1'b0; pend = 1'b0; end
      if (t) ticks++;
      if (comp[d] != prev) begin
        chk("ramp_val", comp[d], v.exp[idx]);
        chk("ramp_gap_ticks", ticks, pps_of[d]);
        chk("ramp_tick_aligned", t, 1);
        if (idx == int'(v.n) - 1) begin
          chk("done_final", done_w[d], 1);
          chk("busy_final", busy_w[d], 0);
        end else begin
          chk("done_early", done_w[d], 0);
          chk("busy_mid", busy_w[d], 1);
          if (v.disturb && idx == 0) begin
            tgt_v[d] = 8'd9; load_v[d] = 1'b1; pend = 1'b1;
          end
        end
        prev = comp[d]; ticks = 0; idx++;
      end else if (done_w[d]) begin
        chk("done_spurious", done_w[d], 0);
      end
    end
    chk("ramp_complete", idx, int'(v.n));
    @(posedge clk); #1;
    chk("done_one_cycle", done_w[d], 0);
    chk("hold_final_val", comp[d], v.exp[int'(v.n) - 1]);
  endtask

  initial begin
    int   cyc;
    logic dirty;

    vecs[0] = '0; vecs[0].dut = 2'd0; vecs[0].tgt = 8'd5;   vecs[0].n = 5'd5;
    for (int i = 0; i < 5; i++) vecs[0].exp[i] = 8'(i + 1);
    vecs[1] = '0; vecs[1].dut = 2'd0; vecs[1].tgt = 8'd20;  vecs[1].n = 5'd15; vecs[1].disturb = 1'b1;
    for (int i = 0; i < 15; i++) vecs[1].exp[i] = 8'(i + 6);
    vecs[2] = '0; vecs[2].dut = 2'd1; vecs[2].tgt = 8'd7;   vecs[2].n = 5'd3;
    vecs[2].exp[0] = 8'd3; vecs[2].exp[1] = 8'd6; vecs[2].exp[2] = 8'd7;
    vecs[3] = '0; vecs[3].dut = 2'd2; vecs[3].tgt = 8'd255; vecs[3].n = 5'd16;
    for (int i = 0; i < 16; i++) vecs[3].exp[i] = (i < 15) ? 8'(16 * (i + 1)) : 8'd255;
    vecs[4] = '0; vecs[4].dut = 2'd2; vecs[4].tgt = 8'd0;   vecs[4].n = 5'd16;
    for (int i = 0; i < 16; i++) vecs[4].exp[i] = (i < 15) ? 8'(239 - 16 * i) : 8'd0;

    // Asynchronous reset, checked between clock edges.
    #3 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_comp", comp[d], 0);
      chk("rst_busy", busy_w[d], 0);
      chk("rst_done", done_w[d], 0);
    end
    chk("rst_tick", tick_w[0], 0);
    #38 rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tick_edge%0d", k), tick_w[0], ((k % 8) == 7) ? 1 : 0);
    end

    // Kill mid-ramp with load held high alongside.
    do_load(0, 8'd5);
    cyc = 0;
    while (comp[0] != 8'd3 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("kill_reach3", comp[0], 3);
    kill_v[0] = 1'b1; load_v[0] = 1'b1; tgt_v[0] = 8'd9;
    @(posedge clk); #1;
    chk("kill_comp", comp[0], 0);
    chk("kill_busy", busy_w[0], 0);
    chk("kill_done", done_w[0], 0);
    @(posedge clk); #1;
    chk("kill_hold_comp", comp[0], 0);
    chk("kill_hold_busy", busy_w[0], 0);
    kill_v[0] = 1'b0; load_v[0] = 1'b0;
    dirty = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (comp[0] != 8'd0 || busy_w[0] || done_w[0]) dirty = 1'b1;
    end
    chk("post_kill_idle", dirty, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Load equal to current value while idle.
    do_load(0, 8'd20);
    chk("eq_done", done_w[0], 1);
    chk("eq_busy", busy_w[0], 0);
    @(posedge clk); #1;
    chk("eq_done_clear", done_w[0], 0);
    chk("eq_busy_hold", busy_w[0], 0);
    chk("eq_comp", comp[0], 20);

    // Reset in the middle of a ramp, asserted between edges.
    do_load(2, 8'd255);
    cyc = 0;
    while (comp[2] == 8'd0 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrst_started", comp[2], 16);
    @(posedge clk); #7;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("midrst_comp", comp[d], 0);
      chk("midrst_busy", busy_w[d], 0);
      chk("midrst_done", done_w[d], 0);
    end
    #30 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("after_rst_busy", busy_w[2], 0);
      chk("after_rst_comp", comp[2], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Controller for the 8-bit PWM generator (base frequency ~12 kHz from a 50 MHz clock). It owns the generator's compare value: it accepts a target duty, slews the compare value toward that target in bounded steps, and changes it only on PWM-period boundaries so the output never sees a mid-period glitch. It also provides an immediate fault shutdown and a period-tick timebase that runs in lockstep with the generator's counter.

Parameters:
PERIOD_CLKS, 4096, clocks per PWM period (50 MHz / 4096 ≈ 12.2 kHz); must match the generator's period.
STEP, 1, compare-value increment or decrement per update (1..255).
PERIODS_PER_STEP, 4, PWM periods between successive updates (>=1).

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous, active-high reset.
load  input  1  one-cycle strobe; captures target when idle.
target  input  8  requested compare value (0..255).
kill  input  1  fault shutdown; level-sensitive, highest priority.
CompDat  output  8  compare value driven to the PWM generator.
busy  output  1  high while a ramp is in progress.
done  output  1  one-cycle pulse when CompDat reaches the target.
period_tick  output  1  one-cycle pulse on the last clock of each PWM period.

Behaviour:
- Reset (asynchronous, any time, including mid-ramp): CompDat=0, busy=0, done=0, period_tick=0, state IDLE, period and step counters=0.
- Timebase:
  - Period counter runs 0..PERIOD_CLKS-1 and wraps.
  - period_tick=1 exactly when the counter equals PERIOD_CLKS-1.
  - The counter is free-running and unaffected by kill and load.
- States: IDLE, RAMP_UP, RAMP_DOWN.
- IDLE:
  - On load=1 (and kill=0), latch target into tgt_q.
  - If tgt_q > CompDat, go to RAMP_UP. If tgt_q < CompDat, go to RAMP_DOWN. busy=1 from the next cycle.
  - If tgt_q == CompDat, stay in IDLE and pulse done on the next cycle. busy stays 0.
- RAMP_UP / RAMP_DOWN:
  - The step counter increments on each period_tick.
  - On the period_tick that completes PERIODS_PER_STEP periods, the step counter clears and CompDat updates at the next clock edge.
  - RAMP_UP: CompDat <= min(CompDat+STEP, tgt_q). RAMP_DOWN: CompDat <= max(CompDat-STEP, tgt_q).
  - Use 9-bit intermediate arithmetic. Results never overshoot the target and never wrap past 255 or 0.
- Completion: on the cycle the update makes CompDat equal tgt_q, the next state is IDLE. From that edge, busy=0 and done=1 for one cycle, coincident with the final CompDat value.
- CompDat changes only on period_tick-aligned edges, except under kill and reset.
- load while busy: ignored. No retarget, no error flag.
- kill=1:
  - Takes effect at the next edge: CompDat=0, state IDLE, busy=0, step counter=0, no done pulse.
  - While kill is held, load is ignored. load and kill in the same cycle: kill wins.
- Starting a ramp: the step counter starts at 0. The first update therefore occurs on the PERIODS_PER_STEP-th period_tick after entering the ramp state.

Decomposition:
- Shared PWM package holds:
  - the state encoding (IDLE/RAMP_UP/RAMP_DOWN);
  - the PWM data width of 8;
  - the default PERIOD_CLKS of 4096, so the generator and sequencer agree on one constant.
- One sub-module is natural: pwm_period_timer (period counter plus period_tick generation). It is reusable by the generator for alignment.
- The rest (FSM, step counter, saturating update) stays in pwm_duty_sequencer.

Test Plan:
Bench uses PERIOD_CLKS=8, 20 ns clock.
1. Reset: assert rst for 40 ns asynchronously to clk -> CompDat=0, busy=0, done=0 immediately. After release, period_tick pulses every 8 clocks, first pulse on the 8th clock.
2. Ramp up: STEP=1, PPS=1, CompDat=0, load target=5 -> CompDat goes 1,2,3,4,5, one change per period_tick. done pulses once with CompDat=5, busy falls the same edge.
3. Saturation: STEP=3, PPS=2, load target=7 from 0 -> CompDat goes 3,6,7, each change 2 ticks apart, no value above 7.
4. Ramp down with no wrap: STEP=16, PPS=1, CompDat=255, load target=0 -> 239,223,...,15,0 (16 updates). Never 255 again, never wraps; done pulses once at 0.
5. Kill mid-ramp: during test 2 at CompDat=3, pulse kill -> CompDat=0 next edge, busy=0, no done. load=1 held together with kill -> no capture.
6. Handshake edges:
   - load target=9 while busy (target 20 ramping) -> ignored, ramp ends at 20.
   - load target=20 while idle at 20 -> done pulse next cycle, busy stays 0.
   - rst mid-ramp -> all outputs to reset values at once.
